// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame geometry
// used by both the receive and transmit halves.
package uart_pkg;

    localparam int STATE_WIDTH        = 3;
    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_OVERSAMPLE = 16;

    typedef enum logic [STATE_WIDTH-1:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } rx_state_t;

    // Width of an index able to address every bit of a word of the given width.
    function automatic int index_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/uart_deserializer.sv
// Receive-side shift register: stores one serial bit at the addressed position
// whenever sample_enable is high. Counterpart of the transmit serializer.
module uart_deserializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int INDEX_WIDTH = index_width(DATA_WIDTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sample_enable,
    input  logic [INDEX_WIDTH-1:0] serial_data_index,
    input  logic                   serial_data,
    output logic [DATA_WIDTH-1:0]  shift_reg
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_reg <= '0;
        end else if (sample_enable) begin
            shift_reg[serial_data_index] <= serial_data;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: two-flop synchroniser, start-bit qualification, mid-bit sampling LSB
// first and stop-bit check. Even parity checking is added when UART_RX_PARITY_EN is defined.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_tick,
    input  logic                  rx_serial,
    output logic [DATA_WIDTH-1:0] parallel_data,
    output logic                  data_valid,
    output logic                  framing_error,
    output logic                  parity_error,
    output logic                  busy
);

    localparam int TICK_WIDTH  = $clog2(OVERSAMPLE);
    localparam int INDEX_WIDTH = index_width(DATA_WIDTH);

    localparam logic [TICK_WIDTH-1:0]  TICK_MID  = TICK_WIDTH'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_WIDTH-1:0]  TICK_LAST = TICK_WIDTH'(OVERSAMPLE - 1);
    localparam logic [INDEX_WIDTH-1:0] BIT_LAST  = INDEX_WIDTH'(DATA_WIDTH - 1);

    rx_state_t              state;
    logic [TICK_WIDTH-1:0]  tick_cnt;
    logic [INDEX_WIDTH-1:0] bit_idx;
    logic                   rx_meta;
    logic                   rx_s;
    logic                   sample_enable;
    logic [DATA_WIDTH-1:0]  shift_reg;

`ifdef UART_RX_PARITY_EN
    logic                   parity_bad;
`else
    assign parity_error = 1'b0;
`endif

    // Both flops reset to the idle-high line level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_serial;
            rx_s    <= rx_meta;
        end
    end

    assign sample_enable = sample_tick && (state == DATA) && (tick_cnt == TICK_LAST);

    uart_deserializer #(
        .DATA_WIDTH  (DATA_WIDTH),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) deserializer (
        .clk               (clk),
        .reset             (reset),
        .sample_enable     (sample_enable),
        .serial_data_index (bit_idx),
        .serial_data       (rx_s),
        .shift_reg         (shift_reg)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            tick_cnt      <= '0;
            bit_idx       <= '0;
            parallel_data <= '0;
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
            busy          <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error  <= 1'b0;
            parity_bad    <= 1'b0;
`endif
        end else begin
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error  <= 1'b0;
`endif
            if (sample_tick) begin
                case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            state    <= START;
                            tick_cnt <= '0;
                            busy     <= 1'b1;
                        end
                    end

                    // A start bit that has vanished by mid-bit is treated as line noise.
                    START: begin
                        if (tick_cnt == TICK_MID) begin
                            tick_cnt <= '0;
                            if (!rx_s) begin
                                state   <= DATA;
                                bit_idx <= '0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end

                    DATA: begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            if (bit_idx == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end

`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt   <= '0;
                            parity_bad <= (^shift_reg) ^ rx_s;
                            state      <= STOP;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
`endif

                    // Leaving at mid-stop gives half a bit of margin for a back-to-back start.
                    STOP: begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            if (!rx_s) begin
                                framing_error <= 1'b1;
                                state         <= WAIT_IDLE;
`ifdef UART_RX_PARITY_EN
                            end else if (parity_bad) begin
                                parity_error <= 1'b1;
                                state        <= IDLE;
                                busy         <= 1'b0;
`endif
                            end else begin
                                parallel_data <= shift_reg;
                                data_valid    <= 1'b1;
                                state         <= IDLE;
                                busy          <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end

                    WAIT_IDLE: begin
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end

                    default: begin
                        state    <= IDLE;
                        tick_cnt <= '0;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed scenarios plus randomized frames
// compared against a frame-level model of the expected strobes and received words.
`timescale 1ns/1ps
module tb_uart_rx_core;

    localparam int DW = 8;
    localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif

    localparam int K_VALID   = 0;
    localparam int K_FRAMING = 1;
    localparam int K_PARITY  = 2;
    localparam int K_MULTI   = 3;

    typedef struct {
        int            kind;
        logic [DW-1:0] data;
        int            cycle;
    } event_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          sample_tick;
    logic          rx_serial;
    logic [DW-1:0] parallel_data;
    logic          data_valid;
    logic          framing_error;
    logic          parity_error;
    logic          busy;

    int vector_count     = 0;
    int miscompare_count = 0;
    int tick_period      = 1;
    int tick_phase       = 0;
    int cycle_count      = 0;
    int busy_cycles      = 0;
    int busy_start;

    logic [DW-1:0] last_good = '0;
    logic [DW-1:0] partial_word;
    logic [DW-1:0] rnd_data;
    logic          rnd_stop;
    logic          rnd_par;

    event_t obs_q[$];
    event_t exp_q[$];

    uart_rx_core #(
        .DATA_WIDTH (DW),
        .OVERSAMPLE (OS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_tick   (sample_tick),
        .rx_serial     (rx_serial),
        .parallel_data (parallel_data),
        .data_valid    (data_valid),
        .framing_error (framing_error),
        .parity_error  (parity_error),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Oversample tick: one clk wide, every tick_period clocks.
    initial begin
        sample_tick = 1'b0;
        forever begin
            @(negedge clk);
            if (tick_phase >= tick_period - 1) begin
                tick_phase  = 0;
                sample_tick = 1'b1;
            end else begin
                tick_phase  = tick_phase + 1;
                sample_tick = 1'b0;
            end
        end
    end

    // Records every output strobe with the word presented alongside it.
    initial begin
        event_t ev;
        forever begin
            @(negedge clk);
            cycle_count = cycle_count + 1;
            if (busy === 1'b1) busy_cycles = busy_cycles + 1;
            if (data_valid === 1'b1 || framing_error === 1'b1 || parity_error === 1'b1) begin
                ev.cycle = cycle_count;
                ev.data  = parallel_data;
                if (int'(data_valid) + int'(framing_error) + int'(parity_error) > 1)
                    ev.kind = K_MULTI;
                else if (data_valid)
                    ev.kind = K_VALID;
                else if (framing_error)
                    ev.kind = K_FRAMING;
                else
                    ev.kind = K_PARITY;
                obs_q.push_back(ev);
            end
        end
    end

    initial begin
        #(800_000);
        $display("[TB] FAIL watchdog: run exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vector_count = vector_count + 1;
        if (actual !== expected) begin
            miscompare_count = miscompare_count + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic driveBit(input logic b);
        rx_serial = b;
        repeat (OS * tick_period) @(negedge clk);
    endtask

    // Sends one frame and records the outcome the receiver owes for it.
    task automatic applyStimulus(input logic [DW-1:0] data, input logic stop_bit, input logic par_bit);
        event_t ev;
        driveBit(1'b0);
        for (int i = 0; i < DW; i++) driveBit(data[i]);
        if (PAR_EN != 0) driveBit(par_bit);
        driveBit(stop_bit);
        ev.cycle = 0;
        if (!stop_bit) begin
            ev.kind = K_FRAMING;
        end else if (PAR_EN != 0 && ((^data) ^ par_bit) == 1'b1) begin
            ev.kind = K_PARITY;
        end else begin
            ev.kind   = K_VALID;
            last_good = data;
        end
        ev.data = last_good;
        exp_q.push_back(ev);
    endtask

    task automatic checkEvents(input string tag);
        int n;
        checkOutput({tag, "_strobe_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checkOutput({tag, "_strobe_kind"}, 32'(obs_q[i].kind), 32'(exp_q[i].kind));
            checkOutput({tag, "_parallel_data"}, 32'(obs_q[i].data), 32'(exp_q[i].data));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        reset     = 1'b0;
        rx_serial = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_parallel_data", 32'(parallel_data), 32'd0);
        checkOutput("reset_data_valid", 32'(data_valid), 32'd0);
        checkOutput("reset_framing_error", 32'(framing_error), 32'd0);
        checkOutput("reset_parity_error", 32'(parity_error), 32'd0);
        reset = 1'b1;
        repeat (2 * OS) @(negedge clk);

        // Single clean frame
        applyStimulus(8'hA5, 1'b1, ^8'hA5);
        driveBit(1'b1);
        checkEvents("frame_a5");
        checkOutput("frame_a5_busy_idle", 32'(busy), 32'd0);

        // Back-to-back frames with no idle gap
        applyStimulus(8'h00, 1'b1, ^8'h00);
        applyStimulus(8'hFF, 1'b1, ^8'hFF);
        if (obs_q.size() >= 2)
            checkOutput("b2b_spacing", 32'(obs_q[1].cycle - obs_q[0].cycle), 32'((DW + 2 + PAR_EN) * OS));
        else
            checkOutput("b2b_strobes_seen", 32'(obs_q.size()), 32'd2);
        driveBit(1'b1);
        checkEvents("b2b");

        // Short low glitch on an idle line
        busy_start = busy_cycles;
        rx_serial  = 1'b0;
        repeat (4) @(negedge clk);
        rx_serial = 1'b1;
        repeat (2 * OS) @(negedge clk);
        checkOutput("glitch_busy_cycles", 32'(busy_cycles - busy_start), 32'(OS / 2));
        checkOutput("glitch_busy_idle", 32'(busy), 32'd0);
        checkEvents("glitch");

        // Bad stop bit followed by a long break
        applyStimulus(8'h3C, 1'b0, ^8'h3C);
        repeat (40) driveBit(1'b0);
        checkEvents("framing");
        checkOutput("break_busy_held", 32'(busy), 32'd1);
        driveBit(1'b1);
        driveBit(1'b1);
        checkOutput("break_busy_released", 32'(busy), 32'd0);
        applyStimulus(8'h96, 1'b1, ^8'h96);
        driveBit(1'b1);
        checkEvents("after_break");

        // Reset asserted during bit 4 of a frame
        partial_word = 8'h5A;
        driveBit(1'b0);
        for (int i = 0; i < 4; i++) driveBit(partial_word[i]);
        rx_serial = partial_word[4];
        repeat (OS * tick_period / 2) @(negedge clk);
        reset     = 1'b0;
        rx_serial = 1'b1;
        @(negedge clk);
        checkOutput("mid_reset_busy", 32'(busy), 32'd0);
        checkOutput("mid_reset_parallel_data", 32'(parallel_data), 32'd0);
        last_good = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        driveBit(1'b1);
        driveBit(1'b1);
        checkEvents("mid_reset");
        applyStimulus(8'h81, 1'b1, ^8'h81);
        driveBit(1'b1);
        checkEvents("after_reset");

`ifdef UART_RX_PARITY_EN
        for (int p = 0; p < 2; p++) begin
            tick_period = (p == 0) ? 1 : 4;
            driveBit(1'b1);
            applyStimulus(8'h07, 1'b1, 1'b1);
            driveBit(1'b1);
            checkEvents("parity_good");
            applyStimulus(8'h07, 1'b1, 1'b0);
            driveBit(1'b1);
            checkEvents("parity_bad");
        end
        tick_period = 1;
`endif

        // Randomized frames; the last group runs with a slower oversample tick
        for (int n = 0; n < 40; n++) begin
            tick_period = (n < 28) ? 1 : 4;
            driveBit(1'b1);
            rnd_data = DW'($urandom);
            rnd_stop = ($urandom_range(7) != 0);
            rnd_par  = (^rnd_data) ^ ($urandom_range(3) == 0);
            applyStimulus(rnd_data, rnd_stop, rnd_par);
            if (!rnd_stop)
                driveBit(1'b1);
            else
                repeat ($urandom_range(20)) @(negedge clk);
            checkEvents("random");
        end

        rx_serial = 1'b1;
        repeat (4 * OS) @(negedge clk);
        checkEvents("final_quiet");
        checkOutput("final_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
        $finish;
    end

endmodule
